// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Lane order is big-endian: lane 0 occupies word bits 31:24 and maps to addr+0.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef logic [BYTE_W-1:0]                byte_t;
  typedef logic [WORD_W-1:0]                word_t;
  typedef logic [0:LANES-1][BYTE_W-1:0]     lanes_t;

  // Split a word into lanes, lane 0 = most significant byte.
  function automatic lanes_t be_unpack(word_t w);
    return lanes_t'(w);
  endfunction

  // Join lanes back into a word, lane 0 = most significant byte.
  function automatic word_t be_pack(lanes_t l);
    return word_t'(l);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core (master) and the data-memory responder (slave).
// resp_err exists only when DATA_MEM_MISALIGN_ERR_EN is defined.
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  import data_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  word_t             req_wdata;
  logic              resp_valid;
  word_t             resp_rdata;
  logic              busy;
`ifdef DATA_MEM_MISALIGN_ERR_EN
  logic              resp_err;
`endif

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
`ifdef DATA_MEM_MISALIGN_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
`ifdef DATA_MEM_MISALIGN_ERR_EN
    , output resp_err
`endif
  );

endinterface

// File: rtl/data_mem_responder_latency_counter.sv
// Loadable down-counter with zero flag; paces the in-flight request.
module latency_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request in flight, fixed LATENCY, byte-lane storage.
// Optional macro DATA_MEM_MISALIGN_ERR_EN: misaligned requests return resp_err
// instead of being silently word-aligned. TOP is assumed to be a power of two.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TOP     = 8192,
  parameter int unsigned LATENCY = 4
) (
  input logic                 clk,
  input logic                 rst_b,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(TOP);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  byte_t             mem [TOP];
  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  word_t             r_wdata;
  logic              ready_q;
  logic              resp_valid_q;
  word_t             resp_rdata_q;
  logic              busy_q;
  logic              accept;
  logic              do_access;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt;
  logic              misaligned;
  logic [IDX_W-1:0]  cap_idx;
  lanes_t            wlanes;
  lanes_t            rlanes;

  assign accept    = bus.req_valid && ready_q;
  assign do_access = (state == WAIT) && cnt_zero;
  assign wlanes    = be_unpack(r_wdata);

`ifdef DATA_MEM_MISALIGN_ERR_EN
  logic resp_err_q;
  assign cap_idx    = bus.req_addr[IDX_W-1:0];
  assign misaligned = (r_idx[1:0] != 2'b00);
  assign bus.resp_err = resp_err_q;
`else
  // Alignment is applied at capture so the stored index is always a word base.
  assign cap_idx    = {bus.req_addr[IDX_W-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  latency_counter #(
    .W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (accept),
    .load_val (CNT_LOAD),
    .dec      (state == WAIT),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Gather the four lanes at the captured word base (index arithmetic wraps mod TOP).
  always_comb begin
    rlanes = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rlanes[i] = mem[r_idx + IDX_W'(i)];
    end
  end

  // Byte storage: cleared by reset, written with four lanes when a store commits.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < TOP; i++) begin
        mem[i] <= '0;
      end
    end else if (do_access && r_we && !misaligned) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        mem[r_idx + IDX_W'(i)] <= wlanes[i];
      end
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
`ifdef DATA_MEM_MISALIGN_ERR_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        r_we    <= bus.req_we;
        r_idx   <= cap_idx;
        r_wdata <= bus.req_wdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state        <= RESPOND;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
`ifdef DATA_MEM_MISALIGN_ERR_EN
            resp_err_q   <= misaligned;
`endif
            if (misaligned) begin
              resp_rdata_q <= '0;
            end else if (!r_we) begin
              resp_rdata_q <= be_pack(rlanes);
            end
          end
        end
        RESPOND: begin
          if (accept) begin
            state   <= WAIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
// Honours DATA_MEM_MISALIGN_ERR_EN when the design is built with it.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int unsigned TOP = 8192;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mdl [TOP];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(32)) bus ();

  data_mem_responder #(
    .ADDR_W  (32),
    .TOP     (TOP),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_base(input logic [31:0] addr);
    return (addr % TOP) & ~32'd3;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned a;
    a = word_base(addr);
    return {mdl[a], mdl[(a + 1) % TOP], mdl[(a + 2) % TOP], mdl[(a + 3) % TOP]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d);
    int unsigned a;
    a = word_base(addr);
    mdl[a]           = d[31:24];
    mdl[(a + 1) % TOP] = d[23:16];
    mdl[(a + 2) % TOP] = d[15:8];
    mdl[(a + 3) % TOP] = d[7:0];
  endtask

  task automatic model_clear();
    for (int i = 0; i < TOP; i++) mdl[i] = 8'h00;
  endtask

  // One complete transaction: wait for ready, issue, scramble inputs, check response.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    int          k;
    int          lat;
    bit          err;
    logic [31:0] exp_rd;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
`ifdef DATA_MEM_MISALIGN_ERR_EN
    err = (addr[1:0] != 2'b00);
`else
    err = 1'b0;
`endif
    exp_rd = err ? 32'h0 : model_read(addr);
    if (we && !err) model_write(addr, wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_notready"}, {31'd0, bus.req_ready}, 32'd0);
    lat = 0;
    for (int e = 1; e <= int'(LAT) + 3 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) lat = e;
    end
    check({tag, "_latency"}, lat, LAT);
    if (!we || err) check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
`ifdef DATA_MEM_MISALIGN_ERR_EN
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, err});
`endif
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int sp;
    int pulses;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_clear();

    // Reset and idle
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    check("idle_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_rdata", bus.resp_rdata, 32'h0);
`ifdef DATA_MEM_MISALIGN_ERR_EN
    check("idle_err", {31'd0, bus.resp_err}, 32'd0);
`endif

    // Store then load, plus byte order peek
    do_req(1'b1, 32'h10, 32'hDEADBEEF, "st10");
    check("peek_0x10", {24'd0, dut.mem[16]}, 32'h0000_00DE);
    check("peek_0x13", {24'd0, dut.mem[19]}, 32'h0000_00EF);
    do_req(1'b0, 32'h10, 32'h0, "ld10");
    check("ld10_value", bus.resp_rdata, 32'hDEADBEEF);

    // Randomized traffic, half of it concentrated in a small window
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      a  = (n % 2 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      do_req(we, a, $urandom, $sformatf("rnd%0d", n));
    end

    // Address wrap at the top of storage
    do_req(1'b1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, "st_wrap");
    do_req(1'b0, TOP - 4, 32'h0, "ld_top");
    check("ld_top_value", bus.resp_rdata, 32'h0BAD_CAFE);

    // Back-to-back loads with req_valid held high
    do_req(1'b1, 32'h0, 32'h1111_2222, "st0");
    do_req(1'b1, 32'h4, 32'h3333_4444, "st4");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 32'h4;
    lat = 0;
    for (int e = 1; e <= int'(LAT) + 3 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) lat = e;
    end
    check("b2b_lat", lat, LAT);
    check("b2b_rdata0", bus.resp_rdata, model_read(32'h0));
    check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sp = 1;
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b_gap", {31'd0, bus.resp_valid}, 32'd0);
    while (!bus.resp_valid && sp < 12) begin
      @(posedge clk);
      #1;
      sp++;
    end
    check("b2b_spacing", sp, LAT + 1);
    check("b2b_rdata4", bus.resp_rdata, model_read(32'h4));
    @(posedge clk);
    #1;

    // Reset while a store is waiting
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    model_clear();
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    do_req(1'b0, 32'h20, 32'h0, "midrst_ld20");
    check("midrst_ld20_value", bus.resp_rdata, 32'h0);

    // Misaligned store
    do_req(1'b1, 32'h20, 32'hA5A5_A5A5, "mis_pre");
    do_req(1'b1, 32'h22, 32'hCAFE_F00D, "mis_st22");
    do_req(1'b0, 32'h20, 32'h0, "mis_ld20");
`ifdef DATA_MEM_MISALIGN_ERR_EN
    check("mis_ld20_value", bus.resp_rdata, 32'hA5A5_A5A5);
`else
    check("mis_ld20_value", bus.resp_rdata, 32'hCAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
